// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Single-port arbiter in front of the 256x8 data memory. The processor core's
// load/store path and the host loader port share the one memory port. At most
// one access is granted per cycle (combinational, zero-cycle arbitration) and
// read data comes back one cycle after the grant. The core normally wins
// contention, but a starvation counter forces a host grant after MAXWAIT lost
// cycles. The host can also take the memory exclusively with h_lock.
//
// Ports:
//   Clk, Reset                     clock (posedge), synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata      core request fields
//   c_gnt, c_rvalid, c_rdata       core grant, read-return pulse, read data
//   h_req/h_we/h_addr/h_wdata      host request fields
//   h_lock                         host asks for exclusive ownership
//   h_gnt, h_rvalid, h_rdata       host grant, read-return pulse, read data
//   mem_addr/mem_we/mem_wdata      to the data memory
//   mem_rdata                      combinational read data from the memory
//   locked                         host lock currently active
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MAXWAIT = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    input  logic          h_lock,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          locked
);

    typedef enum logic {
        ARB,
        LOCK
    } state_t;

    typedef enum logic [1:0] {
        RSEL_NONE,
        RSEL_CORE,
        RSEL_HOST
    } rsel_t;

    localparam logic [3:0] WMAX = 4'(MAXWAIT);

    state_t        state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    rsel_t         rsel_q, rsel_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] h_rdata_q, h_rdata_d;

    // Grants follow the requests combinationally. Nothing is granted while
    // Reset is high, so a request raised during reset cannot touch memory.
    // In LOCK the host owns the port outright; in ARB the core wins a tie
    // unless the host has already lost MAXWAIT consecutive cycles.
    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!Reset) begin
            if (state_q == LOCK) begin
                h_gnt = h_req;
            end else if (h_req && (!c_req || wcnt_q == WMAX)) begin
                h_gnt = 1'b1;
            end else begin
                c_gnt = c_req;
            end
        end
    end

    // Memory port mux: the granted requester drives the port; an idle cycle
    // parks everything at zero so no write can happen without a grant.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (h_gnt) begin
            mem_addr  = h_addr;
            mem_we    = h_we;
            mem_wdata = h_wdata;
        end else if (c_gnt) begin
            mem_addr  = c_addr;
            mem_we    = c_we;
            mem_wdata = c_wdata;
        end
    end

    // Next-state logic: lock entry/exit, the starvation counter, and the
    // read-return tag. Read data is captured from the memory on the grant
    // cycle, so the returned value reflects the memory before any write that
    // commits at the same edge.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rsel_d    = RSEL_NONE;
        c_rdata_d = c_rdata_q;
        h_rdata_d = h_rdata_q;

        case (state_q)
            ARB: begin
                if (h_gnt && h_lock) begin
                    state_d = LOCK;
                end
                if (h_gnt || !h_req) begin
                    wcnt_d = '0;
                end else if (c_gnt && wcnt_q != WMAX) begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            LOCK: begin
                wcnt_d = '0;
                if (!h_req || !h_lock) begin
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
                wcnt_d  = '0;
            end
        endcase

        if (c_gnt && !c_we) begin
            rsel_d    = RSEL_CORE;
            c_rdata_d = mem_rdata;
        end else if (h_gnt && !h_we) begin
            rsel_d    = RSEL_HOST;
            h_rdata_d = mem_rdata;
        end
    end

    // All state registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ARB;
            wcnt_q    <= '0;
            rsel_q    <= RSEL_NONE;
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rsel_q    <= rsel_d;
            c_rdata_q <= c_rdata_d;
            h_rdata_q <= h_rdata_d;
        end
    end

    // Status and read-return outputs are masked while Reset is high so a read
    // granted just before reset never produces a visible pulse or data.
    assign c_rvalid = (rsel_q == RSEL_CORE) && !Reset;
    assign h_rvalid = (rsel_q == RSEL_HOST) && !Reset;
    assign c_rdata  = Reset ? '0 : c_rdata_q;
    assign h_rdata  = Reset ? '0 : h_rdata_q;
    assign locked   = (state_q == LOCK) && !Reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed scoreboard bench for dmem_arbiter. A small behavioural 256x8
// memory sits on the memory port. Each granted read pushes its hand-computed
// return value into a per-requester queue; a monitor pops and compares on
// every rvalid pulse. Grant/lock/port values are checked at the negedge of
// each stimulus cycle.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       c_req = 1'b0, c_we = 1'b0;
    logic [7:0] c_addr = '0, c_wdata = '0;
    logic       c_gnt, c_rvalid;
    logic [7:0] c_rdata;
    logic       h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
    logic [7:0] h_addr = '0, h_wdata = '0;
    logic       h_gnt, h_rvalid;
    logic [7:0] h_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
    logic       locked;

    logic [7:0] mem [256];

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] cq[$];
    logic [7:0] hq[$];

    dmem_arbiter #(.AW(8), .DW(8), .MAXWAIT(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_lock(h_lock),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked)
    );

    always #5 Clk = ~Clk;

    // Behavioural data memory: combinational read, write at posedge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge Clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // One stimulus cycle: drive just after the posedge, return at the negedge
    // so the caller can check the combinational/registered outputs.
    task automatic applyStimulus(input logic cr, input logic cw,
                                 input logic [7:0] ca, input logic [7:0] cd,
                                 input logic hr, input logic hw,
                                 input logic [7:0] ha, input logic [7:0] hd,
                                 input logic hl, input logic rst);
        @(posedge Clk);
        #1;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        h_lock = hl; Reset = rst;
        @(negedge Clk);
    endtask

    // Read-return monitor: every rvalid must match the oldest expectation.
    initial begin
        forever begin
            @(negedge Clk);
            if (c_rvalid) begin
                if (cq.size() == 0) begin
                    checkOutput("c_rvalid_unexpected", 32'(c_rvalid), 32'd0);
                end else begin
                    checkOutput("c_rdata", 32'(c_rdata), 32'(cq.pop_front()));
                end
            end
            if (h_rvalid) begin
                if (hq.size() == 0) begin
                    checkOutput("h_rvalid_unexpected", 32'(h_rvalid), 32'd0);
                end else begin
                    checkOutput("h_rdata", 32'(h_rdata), 32'(hq.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with a host read request held: nothing may be granted.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00, 0, 1);
            checkOutput("rst_h_gnt", 32'(h_gnt), 32'd0);
            checkOutput("rst_c_gnt", 32'(c_gnt), 32'd0);
            checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
            checkOutput("rst_locked", 32'(locked), 32'd0);
            checkOutput("rst_c_rdata", 32'(c_rdata), 32'd0);
            checkOutput("rst_h_rdata", 32'(h_rdata), 32'd0);
        end

        // Idle after reset: port parked at zero.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
            checkOutput("idle_mem_we", 32'(mem_we), 32'd0);
            checkOutput("idle_mem_addr", 32'(mem_addr), 32'd0);
            checkOutput("idle_c_rvalid", 32'(c_rvalid), 32'd0);
            checkOutput("idle_h_rvalid", 32'(h_rvalid), 32'd0);
            checkOutput("idle_wcnt", 32'(dut.wcnt_q), 32'd0);
        end

        // Host preloads 0x5A at 0x40, then core-only read of 0x40.
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h5A, 0, 0);
        checkOutput("hw40_h_gnt", 32'(h_gnt), 32'd1);
        checkOutput("hw40_mem_we", 32'(mem_we), 32'd1);
        checkOutput("hw40_mem_addr", 32'(mem_addr), 32'h40);
        applyStimulus(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        checkOutput("cr40_c_gnt", 32'(c_gnt), 32'd1);
        checkOutput("cr40_h_gnt", 32'(h_gnt), 32'd0);
        cq.push_back(8'h5A);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        checkOutput("cr40_rvalid", 32'(c_rvalid), 32'd1);
        checkOutput("cr40_h_gnt_after", 32'(h_gnt), 32'd0);

        // Host write 0x33 to 0x10 then core read of 0x10 the next cycle.
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h33, 0, 0);
        checkOutput("hw10_mem_we", 32'(mem_we), 32'd1);
        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        checkOutput("cr10_c_gnt", 32'(c_gnt), 32'd1);
        checkOutput("cr10_mem_we", 32'(mem_we), 32'd0);
        cq.push_back(8'h33);

        // Read granted before the write sees the old value; after sees new.
        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        cq.push_back(8'h33);
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h77, 0, 0);
        checkOutput("hw10b_mem_wdata", 32'(mem_wdata), 32'h77);
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0);
        checkOutput("hr10_h_gnt", 32'(h_gnt), 32'd1);
        hq.push_back(8'h77);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);

        // Continuous contention: core x4, host x1, repeating.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 1, 8'(8'h80 + i), 8'(i), 1, 1, 8'(8'hA0 + i), 8'(i), 0, 0);
            checkOutput("cont_c_gnt", 32'(c_gnt), ((i % 5) == 4) ? 32'd0 : 32'd1);
            checkOutput("cont_h_gnt", 32'(h_gnt), ((i % 5) == 4) ? 32'd1 : 32'd0);
            checkOutput("cont_wcnt_le_max", 32'(dut.wcnt_q <= 4'd4), 32'd1);
        end

        // Host lock: acquire alone, then 8 locked writes against a core read.
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'hBF, 8'hEE, 1, 0);
        checkOutput("lock_acq_h_gnt", 32'(h_gnt), 32'd1);
        checkOutput("lock_acq_locked", 32'(locked), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 8'hC3, 8'h00, 1, 1, 8'(8'hC0 + i), 8'(8'h10 + i), 1, 0);
            checkOutput("lock_c_gnt", 32'(c_gnt), 32'd0);
            checkOutput("lock_h_gnt", 32'(h_gnt), 32'd1);
            checkOutput("lock_locked", 32'(locked), 32'd1);
        end
        applyStimulus(1, 0, 8'hC3, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        checkOutput("unlock_c_gnt", 32'(c_gnt), 32'd0);
        checkOutput("unlock_locked", 32'(locked), 32'd1);
        applyStimulus(1, 0, 8'hC3, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        checkOutput("post_lock_c_gnt", 32'(c_gnt), 32'd1);
        checkOutput("post_lock_locked", 32'(locked), 32'd0);
        cq.push_back(8'h13);

        // Host read granted, reset the next cycle: no pulse, data cleared.
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'hC7, 8'h00, 0, 0);
        checkOutput("rr_h_gnt", 32'(h_gnt), 32'd1);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1);
        checkOutput("rr_h_rvalid", 32'(h_rvalid), 32'd0);
        checkOutput("rr_h_rdata", 32'(h_rdata), 32'd0);
        checkOutput("rr_locked", 32'(locked), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
            checkOutput("rr_after_h_rvalid", 32'(h_rvalid), 32'd0);
            checkOutput("rr_after_h_rdata", 32'(h_rdata), 32'd0);
        end

        checkOutput("cq_drained", 32'(cq.size()), 32'd0);
        checkOutput("hq_drained", 32'(hq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
